// File: rtl/pe_accum64.sv
// Streaming signed burst accumulator: sums LEN sign-extended operands into 64 bits.
// Define PE_ACCUM_SAT_EN to saturate on signed overflow instead of wrapping.

module adder64 (
  input  logic [63:0] i_a,
  input  logic [63:0] i_b,
  input  logic        i_cin,
  output logic [63:0] o_sum,
  output logic        o_cout
);
  logic [63:0] w_g, w_p;
  logic [64:0] w_c;

  assign w_g    = i_a & i_b;
  assign w_p    = i_a ^ i_b;
  assign w_c[0] = i_cin;

  // 4-bit lookahead groups; group carries ripple between groups
  for (genvar k = 0; k < 16; k++) begin : g_grp
    localparam int B = 4 * k;
    assign w_c[B+1] = w_g[B] | (w_p[B] & w_c[B]);
    assign w_c[B+2] = w_g[B+1] | (w_p[B+1] & w_g[B]) | (w_p[B+1] & w_p[B] & w_c[B]);
    assign w_c[B+3] = w_g[B+2] | (w_p[B+2] & w_g[B+1]) | (w_p[B+2] & w_p[B+1] & w_g[B])
                    | (w_p[B+2] & w_p[B+1] & w_p[B] & w_c[B]);
    assign w_c[B+4] = w_g[B+3] | (w_p[B+3] & w_g[B+2]) | (w_p[B+3] & w_p[B+2] & w_g[B+1])
                    | (w_p[B+3] & w_p[B+2] & w_p[B+1] & w_g[B])
                    | (w_p[B+3] & w_p[B+2] & w_p[B+1] & w_p[B] & w_c[B]);
  end

  assign o_sum  = w_p ^ w_c[63:0];
  assign o_cout = w_c[64];
endmodule

module pe_accum64 #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CNT_W-1:0]  len,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [63:0]       out_sum,
  output logic              out_ovf,
  input  logic              out_ready,
  output logic              busy
);
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           r_state, w_next;
  logic [63:0]      r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic             r_ovf;

  logic [63:0] w_ext, w_sum, w_acc_nxt;
  logic        w_cout_unused, w_beat, w_ovf_beat;

  if (DATA_W < 64) begin : g_sext
    assign w_ext = {{(64-DATA_W){in_data[DATA_W-1]}}, in_data};
  end else begin : g_noext
    assign w_ext = in_data[63:0];
  end

  adder64 u_add (
    .i_a   (r_acc),
    .i_b   (w_ext),
    .i_cin (1'b0),
    .o_sum (w_sum),
    .o_cout(w_cout_unused)
  );

  assign w_beat     = (r_state == S_ACCUM) && in_valid;
  // same-sign operands producing a different-sign result
  assign w_ovf_beat = (r_acc[63] == w_ext[63]) && (w_sum[63] != r_acc[63]);

`ifdef PE_ACCUM_SAT_EN
  assign w_acc_nxt = !w_ovf_beat ? w_sum :
                     (r_acc[63] ? 64'h8000_0000_0000_0000 : 64'h7FFF_FFFF_FFFF_FFFF);
`else
  assign w_acc_nxt = w_sum;
`endif

  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (r_state)
      S_IDLE:  if (start) w_next = (len == '0) ? S_DONE : S_ACCUM;
      S_ACCUM: begin
        in_ready = 1'b1;
        if (in_valid && r_cnt == CNT_W'(1)) w_next = S_DONE;
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && start) begin
        r_acc <= '0;
        r_ovf <= 1'b0;
        r_cnt <= len;
      end else if (w_beat) begin
        r_acc <= w_acc_nxt;
        r_cnt <= r_cnt - CNT_W'(1);
        r_ovf <= r_ovf | w_ovf_beat;
      end
    end
  end

  assign out_sum = r_acc;
  assign out_ovf = r_ovf;
  assign busy    = (r_state != S_IDLE);
endmodule
